// File: rtl/counter_pkg.sv
// Shared counter constants: default width and the reset polarity used by blocks on this reset convention.
package counter_pkg;
    localparam int unsigned COUNTER_WIDTH_DEFAULT = 4;
    localparam logic        RESET_ACTIVE          = 1'b0;
endpackage

// File: rtl/counter_4bit.sv
// Free-running up-counter with synchronous enable and synchronous active-low reset; out updates one cycle after inputs are sampled.
// tc flags the all-ones state while enabled, so a following stage can be cascaded off it.
module counter_4bit
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset == RESET_ACTIVE) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign out = cnt;

    // Gated by reset so a cascaded stage never counts while this one is being cleared.
    assign tc = (reset != RESET_ACTIVE) && enable && (cnt == {WIDTH{1'b1}});

    a_incr: assert property (@(posedge clock)
        (reset != RESET_ACTIVE) && enable |=> out == ($past(out) + WIDTH'(1)));
    a_hold: assert property (@(posedge clock)
        (reset != RESET_ACTIVE) && !enable |=> out == $past(out));
    a_clear: assert property (@(posedge clock)
        (reset == RESET_ACTIVE) |=> out == '0);

endmodule

// File: tb/tb_counter_4bit.sv
// Directed bench for counter_4bit at WIDTH 4 plus a wrap sweep at WIDTH 1 and 8.
module tb_counter_4bit;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en4   = 1'b0;
    logic       en1   = 1'b0;
    logic       en8   = 1'b0;
    logic [3:0] out4;
    logic [0:0] out1;
    logic [7:0] out8;
    logic       tc4;
    logic       tc1;
    logic       tc8;

    int tests_run = 0;
    int tests_failed = 0;
    int tc_pulses;
    int tc1_pulses;
    int tc8_pulses;

    always #5 clock = ~clock;

    counter_4bit #(.WIDTH(4)) dut4 (.clock(clock), .reset(reset), .enable(en4), .out(out4), .tc(tc4));
    counter_4bit #(.WIDTH(1)) dut1 (.clock(clock), .reset(reset), .enable(en1), .out(out1), .tc(tc1));
    counter_4bit #(.WIDTH(8)) dut8 (.clock(clock), .reset(reset), .enable(en8), .out(out8), .tc(tc8));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held for two edges with enable low.
        step(2);
        check_val("rst_out", 32'(out4), 0);
        check_val("rst_tc", 32'(tc4), 0);
        reset = 1'b1;
        #1;
        check_val("rel_out", 32'(out4), 0);
        check_val("rel_tc", 32'(tc4), 0);

        // 50 enabled edges: out follows i mod 16, tc high only at 15.
        en4 = 1'b1;
        tc_pulses = 0;
        for (int i = 1; i <= 50; i++) begin
            step(1);
            check_val("cnt_out", 32'(out4), 32'(i % 16));
            check_val("cnt_tc", 32'(tc4), (i % 16 == 15) ? 1 : 0);
            if (tc4) tc_pulses++;
        end
        check_val("cnt_final", 32'(out4), 2);
        check_val("tc_pulses", 32'(tc_pulses), 3);

        // Hold for 10 edges.
        en4 = 1'b0;
        #1;
        check_val("hold_tc0", 32'(tc4), 0);
        step(10);
        check_val("hold_out", 32'(out4), 2);
        check_val("hold_tc", 32'(tc4), 0);

        // Wrap 14 -> 15 -> 0 -> 1.
        en4 = 1'b1;
        step(12);
        check_val("wrap_14", 32'(out4), 14);
        check_val("wrap_14_tc", 32'(tc4), 0);
        step(1);
        check_val("wrap_15", 32'(out4), 15);
        check_val("wrap_15_tc", 32'(tc4), 1);
        step(1);
        check_val("wrap_0", 32'(out4), 0);
        check_val("wrap_0_tc", 32'(tc4), 0);
        step(1);
        check_val("wrap_1", 32'(out4), 1);

        // Reset beats enable mid-count at 9, then resume 1, 2, 3.
        step(8);
        check_val("mid_9", 32'(out4), 9);
        reset = 1'b0;
        step(1);
        check_val("mid_rst", 32'(out4), 0);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check_val("resume", 32'(out4), 32'(i));
        end

        // tc must drop as soon as reset goes low at all-ones.
        step(12);
        check_val("tcf_15", 32'(out4), 15);
        check_val("tcf_tc1", 32'(tc4), 1);
        reset = 1'b0;
        #1;
        check_val("tcf_tc0", 32'(tc4), 0);
        step(1);
        check_val("tcf_out", 32'(out4), 0);
        check_val("tcf_tc_after", 32'(tc4), 0);
        reset = 1'b1;
        en4 = 1'b0;

        // Width sweep: WIDTH=1 and WIDTH=8 from a fresh reset.
        reset = 1'b0;
        step(1);
        check_val("w1_rst", 32'(out1), 0);
        check_val("w8_rst", 32'(out8), 0);
        reset = 1'b1;
        en1 = 1'b1;
        en8 = 1'b1;
        tc1_pulses = 0;
        tc8_pulses = 0;
        for (int i = 1; i <= 300; i++) begin
            step(1);
            check_val("w1_out", 32'(out1), 32'(i % 2));
            check_val("w1_tc", 32'(tc1), (i % 2 == 1) ? 1 : 0);
            check_val("w8_out", 32'(out8), 32'(i % 256));
            check_val("w8_tc", 32'(tc8), (i % 256 == 255) ? 1 : 0);
            if (tc1) tc1_pulses++;
            if (tc8) tc8_pulses++;
        end
        check_val("w1_pulses", 32'(tc1_pulses), 150);
        check_val("w8_pulses", 32'(tc8_pulses), 1);
        check_val("w8_final", 32'(out8), 44);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
